// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 encodings and the controller state type.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WRITE,
      RSP
   } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend
// and byte/half merge for sub-word stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] data,
   output logic [31:0] load_val,
   output logic [31:0] merged
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];

      load_val = word;
      case (funct3)
         F3_B:    load_val = {{24{b[7]}}, b};
         F3_BU:   load_val = {24'b0, b};
         F3_H:    load_val = {{16{h[15]}}, h};
         F3_HU:   load_val = {16'b0, h};
         default: load_val = word;
      endcase

      merged = data;
      case (funct3)
         F3_B: begin
            merged = word;
            merged[{off, 3'b000} +: 8] = data[7:0];
         end
         F3_H: begin
            merged = off[1] ? {data[15:0], word[15:0]}
                            : {word[31:16], data[15:0]};
         end
         default: merged = data;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store requester for the word-addressed unified memory;
// sub-word stores are done as read-modify-write.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int IDX_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wen,
   input  logic [31:0] mem_rdata
);

   state_t            state;
   state_t            state_n;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [IDX_W+1:0]  addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       data_q;
   logic              misal;
   logic              illegal;
   logic              oor;
   logic              req_err;
   logic [31:0]       word_idx;
   logic [31:0]       load_val;
   logic [31:0]       merged;

   assign misal = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
   assign illegal = req_we ? (req_funct3 > F3_W)
                           : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
   assign oor     = req_addr >= 32'(DEPTH * 4);
   assign req_err = misal | illegal | oor;

   assign word_idx = 32'(addr_q[IDX_W+1:2]);

   lsu_lane_align u_align (
      .funct3   (f3_q),
      .off      (addr_q[1:0]),
      .word     (mem_rdata),
      .data     (wdata_q),
      .load_val (load_val),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= '0;
         wdata_q <= 32'b0;
         err_q   <= 1'b0;
         data_q  <= 32'b0;
      end else begin
         state <= state_n;
         if (req_valid && req_ready) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[IDX_W+1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
         end
         if (state == ACCESS) data_q <= we_q ? merged : load_val;
      end
   end

   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_addr  = 32'b0;
      mem_wdata = 32'b0;
      mem_wen   = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_n = req_err ? RSP : ACCESS;
         end
         ACCESS: begin
            mem_addr = word_idx;
            state_n  = RSP;
            if (we_q && (f3_q == F3_W)) begin
               mem_wen   = 1'b1;
               mem_wdata = wdata_q;
            end else if (we_q) begin
               state_n = WRITE;
            end
         end
         WRITE: begin
            mem_addr  = word_idx;
            mem_wen   = 1'b1;
            mem_wdata = data_q;
            state_n   = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            state_n   = IDLE;
         end
      endcase
      // reset aborts whatever is in flight, including a pending write
      if (rst) begin
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         mem_addr  = 32'b0;
         mem_wdata = 32'b0;
         mem_wen   = 1'b0;
      end
   end

   assign rsp_err   = rsp_valid & err_q;
   assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? data_q : 32'b0;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store requester that drives the word-addressed unified memory (combinational read, synchronous write, no byte enables) on behalf of the execute stage.
Accepts RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake and converts byte addresses to word indices.
Extracts and extends sub-word load data, and performs read-modify-write for SB/SH.
Returns one response pulse per request, with an error flag for misaligned, illegal or out-of-range accesses.

Parameters:
DEPTH, 32, number of 32-bit words in the memory; legal byte addresses are 0 .. DEPTH*4-1
IDX_W, 5, word-index width, equal to clog2(DEPTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
req_addr  input  32  byte address
req_wdata  input  32  store data; lanes taken from LSBs
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result, extended; 0 for stores and errors
rsp_err  output  1  request rejected, valid with rsp_valid
mem_addr  output  32  word index to memory: zero-extended req_addr[IDX_W+1:2]
mem_wdata  output  32  write data to memory
mem_wen  output  1  memory write enable
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - State goes to IDLE.
  - All outputs read 0 during and after reset: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wen.
  - mem_wen is gated by !rst, so reset in any state aborts the operation with no memory write in that cycle.
- States: IDLE, ACCESS, WRITE, RSP.
- IDLE:
  - req_ready=1 while not in reset; req_ready=0 in every other state.
  - On handshake (req_valid & req_ready), capture we, funct3, addr and wdata.
  - If the request is in error, go to RSP with rsp_err pending; otherwise go to ACCESS.
- Error conditions, checked at accept:
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Illegal funct3: loads 011, 110, 111; stores anything >010.
  - Out of range: addr >= DEPTH*4.
- ACCESS (all accesses): mem_addr = captured word index.
  - Load: register the extracted lane from mem_rdata at the end of the cycle.
    - LB/LBU take byte addr[1:0]; LH/LHU take half addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - Little-endian: byte 0 is bits 7:0.
    - Next state RSP.
  - SW: mem_wen=1 and mem_wdata=req_wdata this cycle. Next state RSP.
  - SB/SH: mem_wen=0.
    - Register a merged word: mem_rdata with the addressed lane replaced by wdata[7:0] or wdata[15:0].
    - Next state WRITE.
- WRITE: mem_addr unchanged, mem_wen=1, mem_wdata=merged word. Next state RSP.
- RSP:
  - rsp_valid=1 for exactly this cycle; rsp_err and rsp_rdata are valid.
  - Next state IDLE.
  - There is no response backpressure.
- Idle values: outside ACCESS/WRITE, mem_addr=0, mem_wdata=0, mem_wen=0.
- mem_wen is never asserted for an errored request.
- Latency, in cycles from the handshake edge to rsp_valid high: LW/LB/LH/LBU/LHU/SW 2; SB/SH 3; errors 1.
- Throughput: a new request can be accepted in the cycle after RSP.
- req_valid held during the busy states has no effect; the request is accepted on the next IDLE.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum with IDLE/ACCESS/WRITE/RSP.
- One natural sub-module, lsu_lane_align (purely combinational):
  - Load extract/extend, and store merge, given funct3, addr[1:0], word and data.
  - The FSM, capture registers and error check stay in lsu_mem_ctrl.

Test Plan:
- Word 3 = 0x11223344. LW 0x0C → rsp_rdata 0x11223344, err 0, rsp_valid 2 cycles after the handshake, mem_wen never high.
- Word 3 = 0x11223344, loads:
  - LB 0x0F → 0x00000011
  - LH 0x0E → 0x00001122
  - Word 3 = 0x8899AABB: LB 0x0C → 0xFFFFFFBB, LBU 0x0C → 0x000000BB, LH 0x0E → 0xFFFF8899
- SB 0x0D, wdata 0xFFFFFFA5, on 0x11223344:
  - Mem write of 0x1122A544 to index 3 exactly once, in the WRITE cycle.
  - rsp_valid 3 cycles after the handshake.
  - Follow-up LW 0x0C → 0x1122A544.
- Error cases, each → rsp_err=1 and rsp_rdata 0 one cycle after the handshake, mem_wen never asserted, memory unchanged:
  - SH 0x0D (misaligned)
  - LW 0x0000_0080 with DEPTH=32 (out of range)
  - Load funct3=3'b011 (illegal)
- Back-to-back handshake:
  - req_valid held high with two LWs → req_ready low while busy; second request accepted the cycle after the first RSP; two separate rsp_valid pulses.
- Reset during SB:
  - Assert rst in the WRITE cycle → mem_wen=0, memory word unchanged, no rsp_valid.
  - After rst is released: req_ready=1 and all outputs 0.
